// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU receive path: sync byte, error codes and
// payload FSM state encodings (8 bits wide, matching the header FSM).
package ccu_pkg;

    localparam logic [7:0] CCU_SYNC_BYTE = 8'h5A;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CHECKSUM = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_LENGTH   = 3'd4;

    typedef enum logic [7:0] {
        IDLE  = 8'd0,
        RECV  = 8'd1,
        CHECK = 8'd2,
        DONE  = 8'd3,
        ERR   = 8'd4
    } pay_state_t;

endpackage

// File: rtl/ccu_byte_fifo.sv
// Synchronous FIFO for payload entries. A push while full succeeds when a
// pop happens in the same cycle. The head reads as zero while empty so the
// output bus is clean after reset.
module ccu_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             wr;
    logic             rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = empty ? '0 : mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; data only, no reset needed
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/ccu_recv_payload_fsm.sv
// Payload stage of the CCU receiver: latches the header, collects
// pack_length bytes into the output FIFO, verifies the XOR checksum byte
// and raises a done or error interrupt for each packet.
module ccu_recv_payload_fsm
    import ccu_pkg::*;
#(
    parameter int MAX_LEN        = 1024,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  crtl_recv_data,
    input  logic        ctrl_recv_en,
    input  logic        hdr_done,
    input  logic [15:0] hdr_pack_id,
    input  logic [7:0]  hdr_pack_type,
    input  logic [15:0] hdr_pack_length,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] cur_pack_id,
    output logic [7:0]  cur_pack_type,
    output logic [15:0] cur_pack_length,
    output logic        busy,
    output logic        int_pay_done,
    output logic        int_pay_error,
    output logic [2:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    pay_state_t  state, state_next;
    logic [15:0] rx_count, rx_n;
    logic [7:0]  xor_acc, xor_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [15:0] id_n, len_n;
    logic [7:0]  type_n;
    logic [2:0]  err_n;

    // Effective packet context: the freshly latched header when a byte
    // arrives together with hdr_done, otherwise the registered values.
    logic [15:0] eff_len, eff_rx;
    logic [7:0]  eff_xor;
    logic [2:0]  eff_err;
    logic        take_recv, take_check, timed_out;

    logic        push, fifo_full, fifo_empty, can_push;
    logic [8:0]  push_data, head;

    assign out_valid = !fifo_empty;
    assign out_last  = head[8];
    assign out_data  = head[7:0];
    assign busy      = (state != IDLE);
    // When full the FIFO is non-empty, so a ready consumer frees a slot this cycle
    assign can_push  = !fifo_full || out_ready;

    ccu_byte_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_data),
        .pop    (out_ready),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state, packet bookkeeping and FIFO push decisions
    always_comb begin
        state_next = state;
        id_n       = cur_pack_id;
        type_n     = cur_pack_type;
        len_n      = cur_pack_length;
        err_n      = err_code;
        rx_n       = rx_count;
        xor_n      = xor_acc;
        tcnt_n     = tcnt;
        eff_len    = cur_pack_length;
        eff_rx     = rx_count;
        eff_xor    = xor_acc;
        eff_err    = err_code;
        take_recv  = 1'b0;
        take_check = 1'b0;
        timed_out  = 1'b0;
        push       = 1'b0;
        push_data  = {1'b0, crtl_recv_data};

        case (state)
            IDLE: begin
                if (hdr_done) begin
                    id_n    = hdr_pack_id;
                    type_n  = hdr_pack_type;
                    len_n   = hdr_pack_length;
                    err_n   = ERR_NONE;
                    rx_n    = '0;
                    xor_n   = '0;
                    tcnt_n  = '0;
                    eff_len = hdr_pack_length;
                    eff_rx  = '0;
                    eff_xor = '0;
                    eff_err = ERR_NONE;
                    if (hdr_pack_length > 16'(MAX_LEN)) begin
                        err_n      = ERR_LENGTH;
                        state_next = ERR;
                    end else if (hdr_pack_length == 16'd0) begin
                        state_next = CHECK;
                        take_check = ctrl_recv_en;
                    end else begin
                        state_next = RECV;
                        take_recv  = ctrl_recv_en;
                    end
                end
            end
            RECV: begin
                if (ctrl_recv_en)                          take_recv = 1'b1;
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) timed_out = 1'b1;
                else                                       tcnt_n    = tcnt + TW'(1);
            end
            CHECK: begin
                if (ctrl_recv_en)                          take_check = 1'b1;
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) timed_out  = 1'b1;
                else                                       tcnt_n     = tcnt + TW'(1);
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (timed_out) begin
            state_next = ERR;
            if (err_code == ERR_NONE) err_n = ERR_TIMEOUT;
        end

        // Payload byte: framing always advances even if the FIFO drops it
        if (take_recv) begin
            push_data = {(eff_rx == eff_len - 16'd1), crtl_recv_data};
            push      = can_push;
            if (!can_push && eff_err == ERR_NONE) err_n = ERR_OVERFLOW;
            xor_n  = eff_xor ^ crtl_recv_data;
            rx_n   = eff_rx + 16'd1;
            tcnt_n = '0;
            if (eff_rx + 16'd1 == eff_len) state_next = CHECK;
        end

        // Checksum byte: never stored, decides DONE versus ERR
        if (take_check) begin
            tcnt_n = '0;
            if (crtl_recv_data == eff_xor && eff_err == ERR_NONE) begin
                state_next = DONE;
            end else begin
                state_next = ERR;
                if (eff_err == ERR_NONE) err_n = ERR_CHECKSUM;
            end
        end
    end

    // Packet context, counters and registered interrupt pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_pack_id     <= '0;
            cur_pack_type   <= '0;
            cur_pack_length <= '0;
            err_code        <= ERR_NONE;
            rx_count        <= '0;
            xor_acc         <= '0;
            tcnt            <= '0;
            int_pay_done    <= 1'b0;
            int_pay_error   <= 1'b0;
        end else begin
            cur_pack_id     <= id_n;
            cur_pack_type   <= type_n;
            cur_pack_length <= len_n;
            err_code        <= err_n;
            rx_count        <= rx_n;
            xor_acc         <= xor_n;
            tcnt            <= tcnt_n;
            int_pay_done    <= (state_next == DONE);
            int_pay_error   <= (state_next == ERR);
        end
    end

endmodule

// File: tb/tb_ccu_recv_payload_fsm.sv
// Randomized self-checking bench for ccu_recv_payload_fsm: a packet-level
// reference model predicts the output stream, interrupts and error codes.
module tb_ccu_recv_payload_fsm;

    localparam int MAX_LEN    = 1024;
    localparam int FIFO_DEPTH = 16;
    localparam int TMO        = 300;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  crtl_recv_data = '0;
    logic        ctrl_recv_en = 1'b0;
    logic        hdr_done = 1'b0;
    logic [15:0] hdr_pack_id = '0;
    logic [7:0]  hdr_pack_type = '0;
    logic [15:0] hdr_pack_length = '0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] cur_pack_id;
    logic [7:0]  cur_pack_type;
    logic [15:0] cur_pack_length;
    logic        busy;
    logic        int_pay_done;
    logic        int_pay_error;
    logic [2:0]  err_code;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int errp_cnt = 0;
    bit rand_ready = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_head;

    ccu_recv_payload_fsm #(
        .MAX_LEN(MAX_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .crtl_recv_data(crtl_recv_data), .ctrl_recv_en(ctrl_recv_en),
        .hdr_done(hdr_done), .hdr_pack_id(hdr_pack_id),
        .hdr_pack_type(hdr_pack_type), .hdr_pack_length(hdr_pack_length),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready),
        .cur_pack_id(cur_pack_id), .cur_pack_type(cur_pack_type),
        .cur_pack_length(cur_pack_length), .busy(busy),
        .int_pay_done(int_pay_done), .int_pay_error(int_pay_error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Stream scoreboard and interrupt counters, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stream_extra got=%h required=nothing", {out_last, out_data});
            end else begin
                exp_head = exp_q.pop_front();
                if ({out_last, out_data} !== exp_head) begin
                    failures++;
                    $display("FAIL stream_byte got=%h required=%h", {out_last, out_data}, exp_head);
                end
            end
        end
        if (int_pay_done)  done_cnt++;
        if (int_pay_error) errp_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] b[$]);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    task automatic idle_gap(input int max_gap);
        int n = $urandom_range(0, max_gap);
        for (int g = 0; g < n; g++) tick();
    endtask

    // Sends one packet and checks the interrupt outcome against the model
    task automatic send_packet(input logic [7:0] b[$], input logic [7:0] ck,
                               input bit coin, input int max_gap, input bit exp_ovf);
        int          len = b.size();
        logic [15:0] id = 16'($urandom);
        logic [7:0]  ty = 8'($urandom);
        logic [2:0]  exp_code;
        bit          good;
        int          first;
        exp_code = exp_ovf ? 3'd2 : (ck != xor_of(b)) ? 3'd1 : 3'd0;
        good = (exp_code == 3'd0);
        for (int i = 0; i < len; i++) begin
            if (!exp_ovf) exp_q.push_back({(i == len - 1), b[i]});
            else if (i < FIFO_DEPTH) exp_q.push_back({1'b0, b[i]});
        end
        hdr_done = 1'b1; hdr_pack_id = id; hdr_pack_type = ty;
        hdr_pack_length = 16'(len);
        if (coin) begin
            ctrl_recv_en = 1'b1;
            crtl_recv_data = (len > 0) ? b[0] : ck;
        end
        tick();
        hdr_done = 1'b0; ctrl_recv_en = 1'b0;
        first = coin ? 1 : 0;
        for (int i = first; i < len; i++) begin
            idle_gap(max_gap);
            if (i == 1 && len >= 3) begin
                hdr_done = 1'b1; hdr_pack_id = ~id; hdr_pack_length = 16'd0;
                tick();
                hdr_done = 1'b0;
            end
            crtl_recv_data = b[i]; ctrl_recv_en = 1'b1;
            tick();
            ctrl_recv_en = 1'b0;
        end
        if (!(coin && len == 0)) begin
            idle_gap(max_gap);
            crtl_recv_data = ck; ctrl_recv_en = 1'b1;
            tick();
            ctrl_recv_en = 1'b0;
        end
        checks += 5;
        if (int_pay_done !== good) begin
            failures++; $display("FAIL pkt_done got=%b required=%b len=%0d", int_pay_done, good, len);
        end
        if (int_pay_error !== !good) begin
            failures++; $display("FAIL pkt_error got=%b required=%b len=%0d", int_pay_error, !good, len);
        end
        if (err_code !== exp_code) begin
            failures++; $display("FAIL pkt_err_code got=%0d required=%0d", err_code, exp_code);
        end
        if (cur_pack_id !== id || cur_pack_type !== ty) begin
            failures++; $display("FAIL pkt_id got=%h/%h required=%h/%h", cur_pack_id, cur_pack_type, id, ty);
        end
        if (cur_pack_length !== 16'(len)) begin
            failures++; $display("FAIL pkt_len got=%0d required=%0d", cur_pack_length, len);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || int_pay_done !== 1'b0 || int_pay_error !== 1'b0) begin
            failures++;
            $display("FAIL pkt_idle got=busy%b/d%b/e%b required=0/0/0", busy, int_pay_done, int_pay_error);
        end
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0; out_ready = 1'b1;
        while (out_valid && n < 64) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=valid%b/left%0d required=0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({out_data, out_last, out_valid, cur_pack_id, cur_pack_type, cur_pack_length,
             busy, int_pay_done, int_pay_error, err_code} !== '0) begin
            failures++;
            $display("FAIL %s got=data%h valid%b id%h len%0d busy%b err%0d required=all_zero",
                     tag, out_data, out_valid, cur_pack_id, cur_pack_length, busy, err_code);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        check_all_zero("reset_state");
        resetn = 1'b1;
        tick();
        check_all_zero("after_reset");
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        out_ready = 1'b1;
        b = '{8'h11, 8'h22, 8'h33};
        send_packet(b, 8'h00, 1'b0, 0, 1'b0);
        drain();
    endtask

    task automatic test_bad_checksum();
        logic [7:0] b[$];
        b = '{8'hA0, 8'h0B};
        send_packet(b, 8'h00, 1'b0, 1, 1'b0);
        drain();
    endtask

    task automatic test_zero_length();
        logic [7:0] b[$];
        b = '{};
        send_packet(b, 8'h00, 1'b1, 0, 1'b0);
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        send_packet(b, xor_of(b), 1'b0, 1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            failures++; $display("FAIL ovf_head got=valid%b/last%b required=1/0", out_valid, out_last);
        end
        drain();
    endtask

    task automatic test_timeout();
        logic [7:0] b[$];
        int n = 0;
        out_ready = 1'b1;
        hdr_done = 1'b1; hdr_pack_id = 16'h0555; hdr_pack_length = 16'd5;
        tick();
        hdr_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            crtl_recv_data = 8'($urandom); ctrl_recv_en = 1'b1;
            exp_q.push_back({1'b0, crtl_recv_data});
            tick();
            ctrl_recv_en = 1'b0;
        end
        while (!int_pay_error && n < TMO + 20) begin tick(); n++; end
        checks += 2;
        if (n < TMO - 1 || n > TMO + 1) begin
            failures++; $display("FAIL timeout_cycles got=%0d required=%0d", n, TMO);
        end
        if (err_code !== 3'd3) begin
            failures++; $display("FAIL timeout_code got=%0d required=3", err_code);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL timeout_busy got=%b required=0", busy);
        end
        drain();
        b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        send_packet(b, 8'h1F, 1'b0, 2, 1'b0);
        drain();
    endtask

    task automatic test_length_and_reset();
        int n = 0;
        int d0, e0;
        out_ready = 1'b1;
        hdr_done = 1'b1; hdr_pack_id = 16'hBEEF; hdr_pack_length = 16'(MAX_LEN + 1);
        crtl_recv_data = 8'h77; ctrl_recv_en = 1'b1;
        tick();
        hdr_done = 1'b0;
        crtl_recv_data = 8'h78;
        while (!int_pay_error && n < 3) begin tick(); n++; end
        ctrl_recv_en = 1'b0;
        checks += 2;
        if (int_pay_error !== 1'b1) begin
            failures++; $display("FAIL len_error got=%b required=1", int_pay_error);
        end
        if (err_code !== 3'd4) begin
            failures++; $display("FAIL len_code got=%0d required=4", err_code);
        end
        tick(); tick();
        drain();
        // Reset while a packet is in flight
        out_ready = 1'b0;
        hdr_done = 1'b1; hdr_pack_id = 16'h1234; hdr_pack_length = 16'd6;
        tick();
        hdr_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            crtl_recv_data = 8'($urandom); ctrl_recv_en = 1'b1;
            tick();
        end
        ctrl_recv_en = 1'b0;
        resetn = 1'b0;
        tick();
        check_all_zero("midpkt_reset");
        resetn = 1'b1;
        d0 = done_cnt; e0 = errp_cnt;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (done_cnt != d0 || errp_cnt != e0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_int got=d%0d/e%0d/busy%b required=d%0d/e%0d/0",
                     done_cnt, errp_cnt, busy, d0, e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        logic [7:0] ck;
        int len;
        for (int p = 0; p < 14; p++) begin
            len = $urandom_range(0, FIFO_DEPTH);
            if (exp_q.size() + len > FIFO_DEPTH) drain();
            b = '{};
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            ck = xor_of(b);
            if ($urandom_range(0, 3) == 0) ck ^= 8'($urandom_range(1, 255));
            rand_ready = 1'b1;
            send_packet(b, ck, 1'($urandom_range(0, 1)), 2, 1'b0);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_timeout();
        test_length_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
